// File: rtl/clock_generator.sv
// Programmable 50%-duty clock divider with glitch-free stop and phase-boundary
// reloads of the half-period; emits single-cycle rise/fall strobes.
//
// state | meaning
// IDLE  | clock parked low, cnt held at 0, half_active tracks half_pend
// RUN   | counting half_active cycles per phase, toggling clock at each boundary
module clock_generator #(
  parameter int DIV_W        = 8,
  parameter int DEFAULT_HALF = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             half_load,
  input  logic [DIV_W-1:0] half_in,
  output logic             clock,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [DIV_W-1:0] half_active
);

  localparam logic [DIV_W-1:0] RST_HALF =
    (DEFAULT_HALF == 0) ? DIV_W'(1) : DIV_W'(DEFAULT_HALF);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_n;
  logic [DIV_W-1:0] cnt, cnt_n;
  logic [DIV_W-1:0] half_pend, half_pend_n;
  logic [DIV_W-1:0] half_active_n;
  logic [DIV_W-1:0] load_val;
  logic             clock_n, rise_n, fall_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      half_pend   <= RST_HALF;
      half_active <= RST_HALF;
      clock       <= 1'b0;
      rise_pulse  <= 1'b0;
      fall_pulse  <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      half_pend   <= half_pend_n;
      half_active <= half_active_n;
      clock       <= clock_n;
      rise_pulse  <= rise_n;
      fall_pulse  <= fall_n;
    end
  end

  always_comb begin
    load_val      = (half_in == '0) ? DIV_W'(1) : half_in;
    // A load on a toggle edge must already govern the phase that starts there
    half_pend_n   = half_load ? load_val : half_pend;
    state_n       = state;
    cnt_n         = cnt;
    clock_n       = clock;
    half_active_n = half_active;

    case (state)
      IDLE: begin
        clock_n       = 1'b0;
        cnt_n         = '0;
        half_active_n = half_pend;
        if (enable) state_n = RUN;
      end
      RUN: begin
        if (!enable && !clock) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == half_active - DIV_W'(1)) begin
          clock_n       = ~clock;
          cnt_n         = '0;
          half_active_n = half_pend_n;
          // a high phase always completes; stopping happens on its falling edge
          if (clock && !enable) state_n = IDLE;
        end else begin
          cnt_n = cnt + DIV_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    rise_n = clock_n & ~clock;
    fall_n = ~clock_n & clock;
  end

endmodule

// File: tb/tb_clock_generator.sv
// Randomized scoreboard bench for clock_generator: a phase-length reference model
// queues the expected outputs per edge and a monitor compares them each negedge.
module tb_clock_generator;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       half_load;
  logic [7:0] half_in;
  logic       clock;
  logic       rise_pulse;
  logic       fall_pulse;
  logic [7:0] half_active;

  int errors = 0;
  int checks = 0;

  clock_generator #(.DIV_W(8), .DEFAULT_HALF(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .half_load   (half_load),
    .half_in     (half_in),
    .clock       (clock),
    .rise_pulse  (rise_pulse),
    .fall_pulse  (fall_pulse),
    .half_active (half_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       c;
    logic       r;
    logic       f;
    logic [7:0] h;
  } exp_t;

  exp_t q[$];

  // Reference model: running flag, output level, cycles left in current phase
  bit m_run;
  bit m_clk;
  int m_left;
  int m_act;
  int m_pend;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run  = 0;
    m_clk  = 0;
    m_left = 0;
    m_act  = 5;
    m_pend = 5;
  endtask

  task automatic model_edge(input bit en, input bit ld, input int hin);
    int   new_pend;
    bit   prev;
    exp_t e;
    new_pend = ld ? ((hin == 0) ? 1 : hin) : m_pend;
    prev     = m_clk;
    if (!m_run) begin
      m_clk = 0;
      m_act = m_pend;
      if (en) begin
        m_run  = 1;
        m_left = m_act;
      end
    end else if (!en && !m_clk) begin
      m_run = 0;
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_clk  = ~m_clk;
        m_act  = new_pend;
        m_left = m_act;
        if (prev && !en) m_run = 0;
      end
    end
    m_pend = new_pend;
    e.c = m_clk;
    e.r = m_clk & ~prev;
    e.f = ~m_clk & prev;
    e.h = 8'(m_act);
    q.push_back(e);
  endtask

  // Called at posedge+2; applies inputs across the next edge
  task automatic step(input bit en, input bit ld, input int hin);
    enable    = en;
    half_load = ld;
    half_in   = 8'(hin);
    @(posedge clk);
    model_edge(en, ld, hin);
    #2;
    half_load = 1'b0;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("clock", clock, e.c);
      check("rise_pulse", rise_pulse, e.r);
      check("fall_pulse", fall_pulse, e.f);
      check("half_active", half_active, e.h);
    end
  end

  initial begin
    reset     = 1'b1;
    enable    = 1'b0;
    half_load = 1'b0;
    half_in   = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    check("reset_clock", clock, 0);
    check("reset_rise", rise_pulse, 0);
    check("reset_fall", fall_pulse, 0);
    check("reset_half", half_active, 5);
    reset = 1'b0;

    // default config: clock first rises on edge 6
    for (int i = 1; i <= 8; i++) begin
      step(1, 0, 0);
      check("first_rise_edge", clock, (i >= 6) ? 1 : 0);
    end

    // load 3 mid high phase, then half_in=0 (treated as 1)
    step(1, 1, 3);
    repeat (20) step(1, 0, 0);
    step(1, 1, 0);
    repeat (10) step(1, 0, 0);
    check("half_zero_is_one", half_active, 1);
    step(1, 1, 5);
    repeat (12) step(1, 0, 0);

    // drop enable two cycles into a high phase
    for (int i = 0; i < 40 && !(m_clk && m_left == m_act); i++) step(1, 0, 0);
    step(1, 0, 0);
    repeat (12) step(0, 0, 0);
    check("parked_low", clock, 0);
    repeat (14) step(1, 0, 0);

    // load 7 on the very edge that toggles
    for (int i = 0; i < 40 && !(m_run && m_left == 1); i++) step(1, 0, 0);
    step(1, 1, 7);
    repeat (18) step(1, 0, 0);

    for (int i = 0; i < 300; i++)
      step(($urandom % 8) != 0, ($urandom % 6) == 0, $urandom % 8);

    // async reset just after a rise, with half_active not at default
    step(1, 1, 3);
    for (int i = 0; i < 40 && !(m_clk && m_left == m_act && m_act == 3 && m_run); i++)
      step(1, 0, 0);
    #4;
    reset = 1'b1;
    #1;
    check("async_clock", clock, 0);
    check("async_rise", rise_pulse, 0);
    check("async_fall", fall_pulse, 0);
    check("async_half", half_active, 5);
    @(posedge clk);
    #2;
    reset = 1'b0;
    model_reset();

    for (int i = 0; i < 200; i++)
      step(($urandom % 10) != 0, ($urandom % 5) == 0, $urandom % 6);

    @(negedge clk);
    #1;
    check("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
